// File: rtl/cpu_step_monitor.sv
// Board-side front end for the single-cycle CPU: turns the step push-button into a clean
// single-step clock and scans CPU debug buses onto a 4-digit 7-segment display.
module cpu_step_monitor #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_DIV     = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_step,
  input  logic [1:0]  sel,
  input  logic [31:0] currPC,
  input  logic [31:0] nextPC,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic [31:0] alu_res,
  input  logic [31:0] dbData,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [15:0] step_count,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------------------
  // Button synchroniser
  // ---------------------------------------------------------------------------
  logic btnMeta;
  logic btnS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btnMeta <= 1'b0;
      btnS    <= 1'b0;
    end else begin
      btnMeta <= btn_step;
      btnS    <= btnMeta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the synced level must disagree with the stable level for
  // DEBOUNCE_CYCLES consecutive clocks; any agreeing cycle restarts the count.
  // ---------------------------------------------------------------------------
  logic            stable;
  logic [DB_W-1:0] dbCnt;
  logic            dbFlip;

  assign dbFlip = (btnS != stable) && (dbCnt == DB_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      dbCnt  <= '0;
    end else if (btnS == stable) begin
      dbCnt <= '0;
    end else if (dbCnt == DB_LAST) begin
      stable <= ~stable;
      dbCnt  <= '0;
    end else begin
      dbCnt <= dbCnt + 1'b1;
    end
  end

  assign cpu_clk = stable;

  // Pulse is raised on the same edge that lifts stable, so it covers the first
  // clock of the new high level only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      step_pulse <= dbFlip & ~stable;
      step_count <= step_count + {15'd0, step_pulse};
    end
  end

  // ---------------------------------------------------------------------------
  // Display value select
  // ---------------------------------------------------------------------------
  logic [15:0] dispValue;
  logic [15:0] dispNext;

  always_comb begin
    dispNext = 16'h0000;
    case (sel)
      2'b00:   dispNext = {currPC[7:0], nextPC[7:0]};
      2'b01:   dispNext = {3'b000, rs, rsData[7:0]};
      2'b10:   dispNext = {3'b000, rt, rtData[7:0]};
      default: dispNext = {alu_res[7:0], dbData[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispValue <= '0;
    end else begin
      dispValue <= dispNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scanner
  // ---------------------------------------------------------------------------
  logic [REF_W-1:0] refreshCnt;
  logic [1:0]       digit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refreshCnt <= '0;
      digit      <= 2'd0;
    end else if (refreshCnt == REF_LAST) begin
      refreshCnt <= '0;
      digit      <= digit + 2'd1;
    end else begin
      refreshCnt <= refreshCnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble select and hex decode; segments are {dp,g,f,e,d,c,b,a}, active-low.
  // ---------------------------------------------------------------------------
  logic [3:0] nibble;
  logic [6:0] hexSeg;
  logic       dpOff;

  always_comb begin
    nibble = 4'h0;
    case (digit)
      2'd0:    nibble = dispValue[3:0];
      2'd1:    nibble = dispValue[7:4];
      2'd2:    nibble = dispValue[11:8];
      default: nibble = dispValue[15:12];
    endcase
  end

  always_comb begin
    hexSeg = 7'h7F;
    case (nibble)
      4'h0: hexSeg = 7'h40;
      4'h1: hexSeg = 7'h79;
      4'h2: hexSeg = 7'h24;
      4'h3: hexSeg = 7'h30;
      4'h4: hexSeg = 7'h19;
      4'h5: hexSeg = 7'h12;
      4'h6: hexSeg = 7'h02;
      4'h7: hexSeg = 7'h78;
      4'h8: hexSeg = 7'h00;
      4'h9: hexSeg = 7'h10;
      4'hA: hexSeg = 7'h08;
      4'hB: hexSeg = 7'h03;
      4'hC: hexSeg = 7'h46;
      4'hD: hexSeg = 7'h21;
      4'hE: hexSeg = 7'h06;
      default: hexSeg = 7'h0E;
    endcase
  end

  // Decimal point on digit 2 separates the two displayed bytes.
  assign dpOff = (digit != 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << digit);
      seg <= {dpOff, hexSeg};
    end
  end

  // Only the low bytes of the CPU buses are shown.
  logic unusedBits;
  assign unusedBits = ^{currPC[31:8], nextPC[31:8], rsData[31:8], rtData[31:8],
                        alu_res[31:8], dbData[31:8]};

endmodule

// File: tb/tb_cpu_step_monitor.sv
// Directed bench for cpu_step_monitor with short debounce and refresh periods.
module tb_cpu_step_monitor;

  logic        clk;
  logic        reset;
  logic        btn_step;
  logic [1:0]  sel;
  logic [31:0] currPC;
  logic [31:0] nextPC;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] alu_res;
  logic [31:0] dbData;
  logic        cpu_clk;
  logic        step_pulse;
  logic [15:0] step_count;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks;
  int failures;

  cpu_step_monitor #(
    .DEBOUNCE_CYCLES(4),
    .REFRESH_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_step(btn_step),
    .sel(sel),
    .currPC(currPC),
    .nextPC(nextPC),
    .rs(rs),
    .rt(rt),
    .rsData(rsData),
    .rtData(rtData),
    .alu_res(alu_res),
    .dbData(dbData),
    .cpu_clk(cpu_clk),
    .step_pulse(step_pulse),
    .step_count(step_count),
    .an(an),
    .seg(seg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; btn_step = 1'b0; sel = 2'b00;
    currPC = '0; nextPC = '0; rs = '0; rt = '0;
    rsData = '0; rtData = '0; alu_res = '0; dbData = '0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg: got %h want ff", seg); end
    checks++; if (cpu_clk !== 1'b0) begin failures++; $display("FAIL reset_cpu_clk: got %b want 0", cpu_clk); end
    checks++; if (step_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b want 0", step_pulse); end
    checks++; if (step_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", step_count); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (an !== 4'b1110) begin failures++; $display("FAIL release_an: got %b want 1110", an); end
  endtask

  task automatic test_bounce();
    int seen_clk;
    int seen_pulse;
    seen_clk = 0; seen_pulse = 0;
    btn_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_clk) seen_clk++;
      if (step_pulse) seen_pulse++;
    end
    btn_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_clk) seen_clk++;
      if (step_pulse) seen_pulse++;
    end
    checks++; if (seen_clk !== 0) begin failures++; $display("FAIL bounce_cpu_clk: high cycles %0d want 0", seen_clk); end
    checks++; if (seen_pulse !== 0) begin failures++; $display("FAIL bounce_pulse: pulses %0d want 0", seen_pulse); end
    checks++; if (step_count !== 16'd0) begin failures++; $display("FAIL bounce_count: got %0d want 0", step_count); end
  endtask

  task automatic test_clean_press();
    int rise_at;
    int fall_at;
    int pulses;
    int rel_pulses;
    logic pulse_at_rise;
    rise_at = -1; fall_at = -1; pulses = 0; rel_pulses = 0; pulse_at_rise = 1'b0;
    btn_step = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (cpu_clk && rise_at < 0) begin rise_at = n; pulse_at_rise = step_pulse; end
      if (step_pulse) pulses++;
    end
    checks++; if (rise_at !== 6) begin failures++; $display("FAIL press_rise: after %0d clks want 6", rise_at); end
    checks++; if (pulse_at_rise !== 1'b1) begin failures++; $display("FAIL press_pulse_align: got %b want 1", pulse_at_rise); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL press_pulses: got %0d want 1", pulses); end
    checks++; if (step_count !== 16'd1) begin failures++; $display("FAIL press_count: got %0d want 1", step_count); end
    btn_step = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (!cpu_clk && fall_at < 0) fall_at = n;
      if (step_pulse) rel_pulses++;
    end
    checks++; if (fall_at !== 6) begin failures++; $display("FAIL release_fall: after %0d clks want 6", fall_at); end
    checks++; if (rel_pulses !== 0) begin failures++; $display("FAIL release_pulses: got %0d want 0", rel_pulses); end
    checks++; if (step_count !== 16'd1) begin failures++; $display("FAIL release_count: got %0d want 1", step_count); end
  endtask

  task automatic test_display_pc();
    logic [7:0] exp_q[$];
    logic [3:0] seen;
    int d;
    exp_q = {8'h80, 8'hC0, 8'h19, 8'hC0};
    seen = 4'b0000;
    sel = 2'b00; currPC = 32'h0000_0004; nextPC = 32'h0000_0008;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      checks++;
      if (d < 0) begin
        failures++; $display("FAIL pc_anode: got %b want one-hot low", an);
      end else begin
        seen[d] = 1'b1;
        if (seg !== exp_q[d]) begin failures++; $display("FAIL pc_seg_d%0d: got %h want %h", d, seg, exp_q[d]); end
      end
    end
    checks++; if (seen !== 4'b1111) begin failures++; $display("FAIL pc_scan_cover: got %b want 1111", seen); end
  endtask

  task automatic test_display_regs();
    logic [7:0] exp_q[$];
    logic [3:0] seen;
    int d;
    for (int v = 0; v < 3; v++) begin
      case (v)
        0: begin sel = 2'b01; rs = 5'd17; rsData = 32'h1234_56AB; exp_q = {8'h83, 8'h88, 8'h79, 8'hF9}; end
        1: begin sel = 2'b10; rt = 5'd3;  rtData = 32'hDEAD_BEF0; exp_q = {8'hC0, 8'h8E, 8'h30, 8'hC0}; end
        default: begin sel = 2'b11; alu_res = 32'h0000_005A; dbData = 32'hFFFF_FFC7;
                       exp_q = {8'hF8, 8'hC6, 8'h08, 8'h92}; end
      endcase
      seen = 4'b0000;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        case (an)
          4'b1110: d = 0;
          4'b1101: d = 1;
          4'b1011: d = 2;
          4'b0111: d = 3;
          default: d = -1;
        endcase
        checks++;
        if (d < 0) begin
          failures++; $display("FAIL regs%0d_anode: got %b want one-hot low", v, an);
        end else begin
          seen[d] = 1'b1;
          if (seg !== exp_q[d]) begin failures++; $display("FAIL regs%0d_seg_d%0d: got %h want %h", v, d, seg, exp_q[d]); end
        end
      end
      checks++; if (seen !== 4'b1111) begin failures++; $display("FAIL regs%0d_scan_cover: got %b want 1111", v, seen); end
    end
  endtask

  task automatic test_reset_mid_press();
    int waited;
    int rise_at;
    int pulses;
    btn_step = 1'b1;
    waited = 0;
    while (!cpu_clk && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (cpu_clk !== 1'b1) begin failures++; $display("FAIL midpress_rise: cpu_clk %b want 1 within 20 clks", cpu_clk); end
    @(negedge clk);
    checks++; if (step_count !== 16'd2) begin failures++; $display("FAIL back_to_back_count: got %0d want 2", step_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (cpu_clk !== 1'b0) begin failures++; $display("FAIL midpress_reset_clk: got %b want 0", cpu_clk); end
    checks++; if (step_count !== 16'd0) begin failures++; $display("FAIL midpress_reset_count: got %0d want 0", step_count); end
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL midpress_reset_an: got %b want 1111", an); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rise_at = -1; pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (cpu_clk && rise_at < 0) rise_at = n;
      if (step_pulse) pulses++;
    end
    checks++; if (rise_at !== 6) begin failures++; $display("FAIL midpress_restep: after %0d clks want 6", rise_at); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL midpress_pulses: got %0d want 1", pulses); end
    checks++; if (step_count !== 16'd1) begin failures++; $display("FAIL midpress_count: got %0d want 1", step_count); end
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_bounce();
    test_clean_press();
    test_display_pc();
    test_display_regs();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
